// File: rtl/image_pkg.sv
// Shared constants for the 240x240 image memory and the writer FSM state encoding.
// Used by both the write side and the display-side address generator.
package image_pkg;

    localparam int SRC_W  = 480;
    localparam int SRC_H  = 480;
    localparam int DIV_BY = 1;
    localparam int IMG_W  = SRC_W >> DIV_BY;
    localparam int IMG_H  = SRC_H >> DIV_BY;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Counter width able to hold the saturation value max(w, h).
    function automatic int cnt_width(input int w, input int h);
        return $clog2(((w > h) ? w : h) + 1);
    endfunction

endpackage

// File: rtl/image_frame_writer_raster_decimator.sv
// Raster position tracking for the frame writer: x/y counters, keep decision and
// the running row base, so the write address is formed without a multiplier.
module raster_decimator #(
    parameter int SRC_W  = 480,
    parameter int SRC_H  = 480,
    parameter int DIV_BY = 1,
    parameter int IMG_W  = 240,
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              beat,
    input  logic              sof,
    input  logic              eol,
    output logic              keep,
    output logic [ADDR_W-1:0] addr,
    output logic              last_line
);

    localparam logic [CNT_W-1:0]  X_MAX    = CNT_W'(SRC_W);
    localparam logic [CNT_W-1:0]  Y_MAX    = CNT_W'(SRC_H);
    localparam logic [CNT_W-1:0]  Y_LAST   = CNT_W'(SRC_H - 1);
    localparam logic [CNT_W-1:0]  SUB_MASK = CNT_W'((1 << DIV_BY) - 1);
    localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0]  ZERO     = {CNT_W{1'b0}};
    localparam logic [ADDR_W-1:0] PITCH    = ADDR_W'(IMG_W);

    logic [CNT_W-1:0]  x_q, x_d, y_q, y_d, x_eff, y_eff;
    logic [ADDR_W-1:0] row_base_q, row_base_d, rb_eff;

    // A sof beat is evaluated as position (0,0) regardless of the old counters.
    always_comb begin
        x_eff      = sof ? ZERO : x_q;
        y_eff      = sof ? ZERO : y_q;
        rb_eff     = sof ? {ADDR_W{1'b0}} : row_base_q;
        keep       = ((x_eff & SUB_MASK) == ZERO) && ((y_eff & SUB_MASK) == ZERO) &&
                     (x_eff < X_MAX) && (y_eff < Y_MAX);
        addr       = rb_eff + ADDR_W'(x_eff >> DIV_BY);
        last_line  = (y_q == Y_LAST);
        x_d        = x_q;
        y_d        = y_q;
        row_base_d = row_base_q;
        if (beat) begin
            if (eol) begin
                x_d        = ZERO;
                y_d        = (y_eff < Y_MAX) ? (y_eff + ONE) : y_eff;
                row_base_d = ((y_eff & SUB_MASK) == SUB_MASK) ? (rb_eff + PITCH) : rb_eff;
            end else begin
                x_d        = (x_eff < X_MAX) ? (x_eff + ONE) : X_MAX;
                y_d        = y_eff;
                row_base_d = rb_eff;
            end
        end else begin
            x_d        = x_q;
            y_d        = y_q;
            row_base_d = row_base_q;
        end
    end

    // Position state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q        <= ZERO;
            y_q        <= ZERO;
            row_base_q <= {ADDR_W{1'b0}};
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            row_base_q <= row_base_d;
        end
    end

endmodule

// File: rtl/image_frame_writer.sv
// Decimating raster-to-BRAM frame writer: FSM, registered write port and bank logic.
// Optional DOUBLE_BUFFER_EN adds a wr_bank output (MSB of the physical write address).
module image_frame_writer #(
    parameter int SRC_W  = image_pkg::SRC_W,
    parameter int SRC_H  = image_pkg::SRC_H,
    parameter int DIV_BY = image_pkg::DIV_BY,
    parameter int IMG_W  = image_pkg::IMG_W,
    parameter int DATA_W = image_pkg::DATA_W,
    parameter int ADDR_W = image_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_eol,
    input  logic [DATA_W-1:0] pix_data,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_abort,
`ifdef DOUBLE_BUFFER_EN
    output logic              wr_bank,
`endif
    output logic              disp_bank
);
    import image_pkg::*;

    localparam int CNT_W = cnt_width(SRC_W, SRC_H);

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d, busy_q, busy_d, done_q, done_d, abort_q, abort_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              final_s, sof_s, beat_s, keep_s, last_line_s;
    logic [ADDR_W-1:0] addr_s;

    raster_decimator #(
        .SRC_W (SRC_W),
        .SRC_H (SRC_H),
        .DIV_BY(DIV_BY),
        .IMG_W (IMG_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) u_dec (
        .clk      (clk),
        .reset    (reset),
        .beat     (beat_s),
        .sof      (sof_s),
        .eol      (pix_eol),
        .keep     (keep_s),
        .addr     (addr_s),
        .last_line(last_line_s)
    );

    // The final eol of a frame wins over a coincident sof.
    always_comb begin
        final_s = pix_valid && pix_eol && last_line_s && (state_q == ST_ACTIVE);
        sof_s   = pix_valid && pix_sof &&
                  ((state_q == ST_IDLE) || ((state_q == ST_ACTIVE) && !final_s));
        beat_s  = pix_valid && ((state_q == ST_ACTIVE) || sof_s);
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = sof_s ? ST_ACTIVE : ST_IDLE;
            ST_ACTIVE: state_d = final_s ? ST_DONE : ST_ACTIVE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        we_d    = beat_s && keep_s;
        waddr_d = addr_s;
        wdata_d = pix_data;
        busy_d  = (state_d == ST_ACTIVE);
        done_d  = (state_d == ST_DONE);
        abort_d = sof_s && (state_q == ST_ACTIVE);
    end

    // FSM and registered write/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            waddr_q <= {ADDR_W{1'b0}};
            wdata_q <= {DATA_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    assign we          = we_q;
    assign waddr       = waddr_q;
    assign wdata       = wdata_q;
    assign busy        = busy_q;
    assign frame_done  = done_q;
    assign frame_abort = abort_q;

`ifdef DOUBLE_BUFFER_EN
    logic bank_q, bank_d, disp_q, disp_d, wbank_q, wbank_d;

    // Banks swap at the end of the DONE cycle, after the frame's last write has gone out.
    always_comb begin
        if (state_q == ST_DONE) begin
            bank_d = ~bank_q;
            disp_d = bank_q;
        end else begin
            bank_d = bank_q;
            disp_d = disp_q;
        end
        wbank_d = bank_q;
    end

    // Bank registers; wbank_q travels with the registered write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_q  <= 1'b0;
            disp_q  <= 1'b0;
            wbank_q <= 1'b0;
        end else begin
            bank_q  <= bank_d;
            disp_q  <= disp_d;
            wbank_q <= wbank_d;
        end
    end

    assign wr_bank   = wbank_q;
    assign disp_bank = disp_q;
`else
    assign disp_bank = 1'b0;
`endif

endmodule

// File: tb/tb_image_frame_writer.sv
// Directed self-checking bench for image_frame_writer on a reduced 32x16 source raster.
module tb_image_frame_writer;

    localparam int W = 32;
    localparam int H = 16;
    localparam int IW = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0, pix_sof = 1'b0, pix_eol = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic        we, busy, frame_done, frame_abort, disp_bank;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic        wr_bank_o;

    int errors = 0;
    int checks = 0;
    int wr_count, done_cnt, abort_cnt, bank1_cnt;
    int last_addr;
    logic [7:0] mem [0:255];
    logic       wrote [0:255];

    image_frame_writer #(
        .SRC_W(W), .SRC_H(H), .DIV_BY(1), .IMG_W(IW), .DATA_W(8), .ADDR_W(16)
    ) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_eol(pix_eol), .pix_data(pix_data), .we(we), .waddr(waddr), .wdata(wdata),
        .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort),
`ifdef DOUBLE_BUFFER_EN
        .wr_bank(wr_bank_o),
`endif
        .disp_bank(disp_bank)
    );

`ifndef DOUBLE_BUFFER_EN
    assign wr_bank_o = 1'b0;
`endif

    always #5 clk = ~clk;

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            wr_count++;
            last_addr = int'(waddr);
            mem[waddr[7:0]] = wdata;
            wrote[waddr[7:0]] = 1'b1;
            if (wr_bank_o === 1'b1) bank1_cnt++;
        end
        if (frame_done === 1'b1) done_cnt++;
        if (frame_abort === 1'b1) abort_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic clear_sb();
        wr_count = 0; done_cnt = 0; abort_cnt = 0; bank1_cnt = 0; last_addr = -1;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'd0;
            wrote[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_sb();
    endtask

    task automatic send_pix(input logic sof, input logic eol, input logic [7:0] d);
        @(posedge clk);
        #1;
        pix_valid = 1'b1; pix_sof = sof; pix_eol = eol; pix_data = d;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        pix_valid = 1'b0; pix_sof = 1'b0; pix_eol = 1'b0;
    endtask

    task automatic send_line(input int y, input int len, input logic sof_first);
        for (int x = 0; x < len; x++)
            send_pix(sof_first && (x == 0), x == len - 1, 8'((y * W + x) & 255));
    endtask

    task automatic send_frame();
        for (int y = 0; y < H; y++) send_line(y, W, y == 0);
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_frame(input string tag);
        int bad;
        bad = 0;
        for (int y = 0; y < H; y += 2)
            for (int x = 0; x < W; x += 2)
                if (!wrote[(y / 2) * IW + x / 2] ||
                    mem[(y / 2) * IW + x / 2] != 8'((y * W + x) & 255)) bad++;
        chk({tag, "_sweep_bad"}, bad, 0);
        chk({tag, "_wr_count"}, wr_count, 128);
        chk({tag, "_last_addr"}, last_addr, 127);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_abort_cnt"}, abort_cnt, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        clear_sb();
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we", we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_abort", frame_abort, 0);
        chk("rst_disp", disp_bank, 0);
        #1 reset = 1'b0;
        clear_sb();

        // Beats before any sof are ignored, then sof writes address 0
        for (int i = 0; i < 5; i++) send_pix(1'b0, i == 4, 8'(i + 1));
        idle();
        @(negedge clk);
        chk("nosof_wr", wr_count, 0);
        chk("nosof_busy", busy, 0);
        send_pix(1'b1, 1'b0, 8'hA5);
        idle();
        @(negedge clk);
        chk("sof_we", we, 1);
        chk("sof_waddr", waddr, 0);
        chk("sof_wdata", wdata, 8'hA5);
        chk("sof_busy", busy, 1);

        // Full frame
        do_reset();
        send_frame();
        chk("f1_mem1", mem[1], 8'd2);
        chk("f1_mem16", mem[16], 8'd64);
        chk("f1_mem127", mem[127], 8'd222);
        check_frame("f1");

        // Abort: sof at (x=10, y=5)
        do_reset();
        for (int y = 0; y < 5; y++) send_line(y, W, y == 0);
        for (int x = 0; x < 10; x++) send_pix(1'b0, 1'b0, 8'(x));
        send_pix(1'b1, 1'b0, 8'h3C);
        idle();
        @(negedge clk);
        chk("abort_pulse", frame_abort, 1);
        chk("abort_we", we, 1);
        chk("abort_waddr", waddr, 0);
        chk("abort_wdata", wdata, 8'h3C);
        @(negedge clk);
        chk("abort_pulse_end", frame_abort, 0);
        send_pix(1'b0, 1'b0, 8'h11);
        send_pix(1'b0, 1'b0, 8'h22);
        idle();
        @(negedge clk);
        chk("abort_next_waddr", waddr, 1);
        chk("abort_next_wdata", wdata, 8'h22);
        chk("abort_cnt", abort_cnt, 1);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_busy", busy, 1);

        // Overlong first line (40 beats), then two normal lines
        do_reset();
        for (int x = 0; x < 40; x++) send_pix(x == 0, x == 39, 8'(x));
        idle();
        @(negedge clk);
        chk("long_wr", wr_count, 16);
        chk("long_last", last_addr, 15);
        chk("long_mem15", mem[15], 8'd30);
        send_line(1, W, 1'b0);
        send_line(2, W, 1'b0);
        idle();
        @(negedge clk);
        chk("long_total", wr_count, 32);
        chk("long_row2_last", last_addr, 31);
        chk("long_row2_first", mem[16], 8'd64);

        // Reset mid-frame with a write in flight, then a clean frame
        do_reset();
        for (int y = 0; y < 4; y++) send_line(y, W, y == 0);
        for (int x = 0; x < 5; x++) send_pix(1'b0, 1'b0, 8'(x));
        @(posedge clk);
        #1 reset = 1'b1;
        pix_valid = 1'b0;
        #1;
        chk("midrst_we", we, 0);
        chk("midrst_busy", busy, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_sb();
        send_frame();
        check_frame("f2");

`ifdef DOUBLE_BUFFER_EN
        // Two frames: second goes to bank 1, display follows the finished bank
        do_reset();
        send_frame();
        chk("db_f1_bank1", bank1_cnt, 0);
        chk("db_disp1", disp_bank, 0);
        clear_sb();
        send_frame();
        chk("db_f2_bank1", bank1_cnt, 128);
        chk("db_disp2", disp_bank, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
